// File: rtl/ad7226_pkg.sv
// Shared types and constants for the AD7226 serial reader.
package ad7226_pkg;

  // Reader FSM states; encoding is exposed on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4,
    ST_QUIET = 3'd5
  } state_e;

  localparam int FRAME_BITS   = 16;
  localparam int DATA_MSB_IDX = 2;
  localparam int DATA_W       = 12;

  // Frame bits 0,1,14,15 are pads. Bit 0 ends up in shift[15], so the pads
  // sit at shift positions 15,14,1,0.
  localparam logic [FRAME_BITS-1:0] PAD_MASK = 16'hC003;

  // Sample field of a fully shifted frame: frame bits 2..13 = shift[13:2].
  function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_BITS-1:0] sh);
    return sh[FRAME_BITS-1-DATA_MSB_IDX -: DATA_W];
  endfunction

  // Any pad bit set marks the frame as suspect.
  function automatic logic frame_err(input logic [FRAME_BITS-1:0] sh);
    return |(sh & PAD_MASK);
  endfunction

  // Chip-select is asserted only while bits are being clocked.
  function automatic logic frame_active(input state_e s);
    return (s == ST_SETUP) || (s == ST_LOW) || (s == ST_HIGH);
  endfunction

endpackage

// File: rtl/ad7226_tick.sv
// Phase divider: counts 0..CLK_DIV-1 and flags the last cycle of a phase.
module ad7226_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count within a phase; restart whenever the FSM changes state.
  always_ff @(posedge clk_sys) begin
    if (rst || clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ad7226_rd.sv
// AD7226 serial frame reader: drives cs_n/sclk, shifts in a 16-bit frame,
// and presents the 12-bit sample with a one-cycle valid strobe.
//
// Interface semantics: start is a level request sampled only in IDLE; while
// busy=1 it is ignored (never queued). vld is a single-cycle push with no
// back-pressure: data/err change only in the vld cycle and hold until the
// next one.
module ad7226_rd
  import ad7226_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int QUIET   = 8
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              start,
  input  logic              sdata,
  output logic              cs_n,
  output logic              sclk,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              vld,
  output logic              err,
  output state_e            dbg_state
);

  // Quiet counter covers QUIET-1 cycles after DONE (values 0..QUIET-2).
  localparam int            QW     = (QUIET > 2) ? $clog2(QUIET - 1) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'((QUIET > 1) ? QUIET - 2 : 0);

  state_e                state;
  state_e                state_nx;
  logic                  tick;
  logic                  div_clr;
  logic                  sample;
  logic                  frame_end;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [QW-1:0]         q_cnt;

  ad7226_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .clr     (div_clr),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-cycle strobes. The bit counter wraps to 0 after the
  // 16th sample, so a HIGH phase ending with bit_cnt==0 is the last one.
  always_comb begin
    state_nx  = state;
    sample    = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SETUP;
      end
      ST_SETUP: begin
        if (tick) begin
          sample   = 1'b1;
          state_nx = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tick) state_nx = ST_HIGH;
      end
      ST_HIGH: begin
        if (tick) begin
          if (bit_cnt == 4'd0) begin
            frame_end = 1'b1;
            state_nx  = ST_DONE;
          end else begin
            sample   = 1'b1;
            state_nx = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        state_nx = (QUIET > 1) ? ST_QUIET : ST_IDLE;
      end
      ST_QUIET: begin
        if (q_cnt == Q_LAST) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Divider restarts on every state change so each phase is CLK_DIV long.
  always_comb begin
    div_clr = 1'b0;
    if (state_nx != state) div_clr = 1'b1;
  end

  // Bit counter: one increment per captured bit, held at 0 while idle.
  always_ff @(posedge clk_sys) begin
    if (rst || (state == ST_IDLE)) begin
      bit_cnt <= 4'd0;
    end else if (sample) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Shift register: MSB-first frame, new bit enters at the LSB.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      shreg <= '0;
    end else if (sample) begin
      shreg <= {shreg[FRAME_BITS-2:0], sdata};
    end
  end

  // Quiet-gap counter runs only while in QUIET.
  always_ff @(posedge clk_sys) begin
    if (rst || (state != ST_QUIET)) begin
      q_cnt <= '0;
    end else begin
      q_cnt <= q_cnt + QW'(1);
    end
  end

  // Pin and status registers follow the next state, giving glitch-free pins
  // that change in the same cycle the state does.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cs_n <= 1'b1;
      sclk <= 1'b1;
      busy <= 1'b0;
    end else begin
      cs_n <= !frame_active(state_nx);
      sclk <= (state_nx != ST_LOW);
      busy <= (state_nx != ST_IDLE);
    end
  end

  // Result registers: loaded as the FSM enters DONE so vld coincides with
  // cs_n returning high; a frame cut short by reset never reaches here.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      data <= '0;
      err  <= 1'b0;
      vld  <= 1'b0;
    end else begin
      vld <= frame_end;
      if (frame_end) begin
        data <= frame_data(shreg);
        err  <= frame_err(shreg);
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ad7226_rd.sv
// Self-checking bench for ad7226_rd with a behavioural AD7226 model.
module tb_ad7226_rd;
  import ad7226_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int QUIET   = 8;
  localparam int CS_LOW  = 33 * CLK_DIV;          // 132
  localparam int PERIOD  = 33 * CLK_DIV + QUIET + 1; // 141
  localparam int GAP     = QUIET + 1;             // 9

  // ---------------- clock / reset / DUT ----------------
  logic        clk_sys = 1'b0;
  logic        rst;
  logic        start;
  logic        sdata = 1'b0;
  logic        cs_n;
  logic        sclk;
  logic        busy;
  logic [11:0] data;
  logic        vld;
  logic        err;
  state_e      dbg_state;

  always #5 clk_sys = ~clk_sys;

  ad7226_rd #(
    .CLK_DIV (CLK_DIV),
    .QUIET   (QUIET)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .start     (start),
    .sdata     (sdata),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .busy      (busy),
    .data      (data),
    .vld       (vld),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [12:0] exp_q[$];   // {err, data} expected per frame started

  // ---------------- ADC model + line monitor ----------------
  // Model: latches its sample when cs_n falls, presents bit 0, advances one
  // bit per sclk falling edge, and steps its sample by 0x111 (mod 4096)
  // after every complete 16-clock frame. force_ones drives all-ones.
  int          pu_gen = 0;
  int          m_pu_seen = 0;
  logic        force_ones = 1'b0;
  logic [11:0] adc_val = 12'h523;
  logic [15:0] m_frame = '0;
  int          m_idx = 0;
  int          m_falls = 0;
  logic        cs_d = 1'b1;
  logic        sclk_d = 1'b1;
  int          low_len = 0;
  int          high_len = 0;
  int          falls = 0;
  int          last_low_len = 0;
  int          last_falls = 0;
  int          last_gap = 0;
  int          cs_fall_cnt = 0;

  always @(negedge clk_sys) begin
    if (pu_gen != m_pu_seen) begin
      adc_val   = 12'h523;
      m_pu_seen = pu_gen;
    end
    if (!cs_n && cs_d) begin
      m_frame = {2'b00, adc_val, 2'b00};
      m_idx   = 0;
      m_falls = 0;
      exp_q.push_back(force_ones ? 13'h1FFF : {1'b0, adc_val});
      last_gap = high_len;
      high_len = 0;
      cs_fall_cnt++;
    end else if (!cs_n && !sclk && sclk_d) begin
      m_falls++;
      falls++;
      if (m_idx < 15) m_idx++;
    end
    if (cs_n && !cs_d) begin
      if (m_falls == 16) adc_val = adc_val + 12'h111;
      last_low_len = low_len;
      last_falls   = falls;
      low_len      = 0;
      falls        = 0;
    end
    if (!cs_n) low_len++;
    else       high_len++;
    sdata  = force_ones ? 1'b1 : m_frame[15 - m_idx];
    cs_d   = cs_n;
    sclk_d = sclk;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    check_cnt++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic sb_check();
    logic [12:0] e;
    if (exp_q.size() == 0) begin
      check_cnt++;
      $display("FAIL sb_empty: vld with data 0x%0h, expected no output", data);
    end else begin
      e = exp_q.pop_front();
      check("sb_frame", 32'({err, data}), 32'(e));
    end
  endtask

  task automatic wait_vld(input string name, output bit ok);
    int n = 0;
    while (!vld && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    ok = vld;
    if (!ok) timeout(name);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  // One start pulse from IDLE; returns the captured sample.
  task automatic run_frame(output logic [11:0] d, output logic e);
    bit ok;
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    check("start_cs_n", 32'(cs_n), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    wait_vld("frame_vld", ok);
    d = data;
    e = err;
    if (ok) begin
      sb_check();
      @(negedge clk_sys);
      check("vld_width", 32'(vld), 32'd0);
    end
    wait_idle();
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    bit          power_up;
    bit          force_ones;
    logic [11:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vec[4];

  initial begin
    logic [11:0] d;
    logic        e;
    logic [11:0] got[12];
    longint      t_vld[3];
    bit          ok;
    int          nv;
    int          fall0;

    // basic frame, pad-error frame, err clears on next frame, one more
    vec[0] = '{1'b1, 1'b0, 12'h523, 1'b0};
    vec[1] = '{1'b1, 1'b1, 12'hFFF, 1'b1};
    vec[2] = '{1'b0, 1'b0, 12'h634, 1'b0};
    vec[3] = '{1'b0, 1'b0, 12'h745, 1'b0};

    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_cs_n",  32'(cs_n),  32'd1);
    check("rst_sclk",  32'(sclk),  32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_vld",   32'(vld),   32'd0);
    check("rst_data",  32'(data),  32'h000);
    check("rst_err",   32'(err),   32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk_sys);

    // ---- table-driven single frames ----
    for (int i = 0; i < 4; i++) begin
      if (vec[i].power_up) pu_gen++;
      force_ones = vec[i].force_ones;
      run_frame(d, e);
      force_ones = 1'b0;
      check($sformatf("tbl%0d_data", i), 32'(d), 32'(vec[i].exp_data));
      check($sformatf("tbl%0d_err", i), 32'(e), 32'(vec[i].exp_err));
      check($sformatf("tbl%0d_cs_low", i), 32'(last_low_len), 32'(CS_LOW));
      check($sformatf("tbl%0d_sclk_falls", i), 32'(last_falls), 32'd16);
    end

    // ---- back-to-back with start held ----
    pu_gen++;
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_vld("b2b_vld", ok);
      if (!ok) break;
      got[f]   = data;
      t_vld[f] = $time;
      sb_check();
      if (f == 2) start = 1'b0;
      @(negedge clk_sys);
    end
    start = 1'b0;
    check("b2b_data0", 32'(got[0]), 32'h523);
    check("b2b_data1", 32'(got[1]), 32'h634);
    check("b2b_data2", 32'(got[2]), 32'h745);
    check("b2b_spacing01", 32'((t_vld[1] - t_vld[0]) / 10), 32'(PERIOD));
    check("b2b_spacing12", 32'((t_vld[2] - t_vld[1]) / 10), 32'(PERIOD));
    check("b2b_cs_gap", 32'(last_gap), 32'(GAP));
    wait_idle();

    // ---- wrap-around over 12 frames ----
    pu_gen++;
    start = 1'b1;
    for (int f = 0; f < 12; f++) begin
      wait_vld("wrap_vld", ok);
      if (!ok) break;
      got[f] = data;
      sb_check();
      if (f == 11) start = 1'b0;
      @(negedge clk_sys);
    end
    start = 1'b0;
    check("wrap_frame10", 32'(got[10]), 32'hFCD);
    check("wrap_frame11", 32'(got[11]), 32'h0DE);
    wait_idle();

    // ---- start pulsed mid-frame is ignored ----
    pu_gen++;
    fall0 = cs_fall_cnt;
    nv    = 0;
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (vld) begin
        nv++;
        if (nv == 1) begin
          sb_check();
          check("ign_vld_cycle", 32'(k), 32'(CS_LOW + 1));
        end
      end
      if (k == CS_LOW)         check("ign_cs_low_end", 32'(cs_n), 32'd0);
      if (k == CS_LOW + QUIET) check("ign_busy_last", 32'(busy), 32'd1);
      if (k == CS_LOW + QUIET + 1) check("ign_busy_fall", 32'(busy), 32'd0);
      @(negedge clk_sys);
    end
    check("ign_vld_count", 32'(nv), 32'd1);
    check("ign_cs_falls", 32'(cs_fall_cnt - fall0), 32'd1);

    // ---- reset in the middle of a frame ----
    pu_gen++;
    @(negedge clk_sys); start = 1'b1;
    @(negedge clk_sys); start = 1'b0;
    repeat (59) @(negedge clk_sys);
    check("mid_cs_low", 32'(cs_n), 32'd0);
    rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0;
    check("mid_rst_cs_n",  32'(cs_n),  32'd1);
    check("mid_rst_sclk",  32'(sclk),  32'd1);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_vld",   32'(vld),   32'd0);
    check("mid_rst_data",  32'(data),  32'h000);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    nv = 0;
    repeat (300) begin
      if (vld) nv++;
      @(negedge clk_sys);
    end
    check("mid_no_vld", 32'(nv), 32'd0);
    run_frame(d, e);
    check("mid_after_data", 32'(d), 32'h523);
    check("mid_after_err", 32'(e), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
